// File: rtl/traffic_phase_arbiter.sv
// -----------------------------------------------------------------------------
// traffic_phase_arbiter
//
// Demand-driven phase controller for a four-approach intersection. Vehicle
// requests are latched per approach and served one at a time in round-robin
// order. Each grant runs green (bounded below by GREEN_MIN), then yellow
// (YELLOW_T), then all-red clearance (ALLRED_T).
//
// Parameters:
//   GREEN_MIN  minimum green cycles            (1..255)
//   GREEN_MAX  upper bound on contested green  (GREEN_MIN..255)
//   YELLOW_T   yellow cycles                   (1..255)
//   ALLRED_T   all-red clearance cycles        (1..255)
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   req[3:0]     in   sensor requests, bit0=N bit1=S bit2=E bit3=W
//   preempt      in   emergency preemption request   (EMERGENCY_PREEMPT_EN only)
//   preempt_dir  in   direction to preempt to        (EMERGENCY_PREEMPT_EN only)
//   n/s/e/w_light out lamp bus {red,yellow,green}
//   phase[1:0]   out  direction currently (or last) served
//   busy         out  high in every state except IDLE
//   count[7:0]   out  cycles spent in the current state, saturating
//   pend[3:0]    out  latched pending requests
//
// Build option: define EMERGENCY_PREEMPT_EN to add emergency preemption.
// -----------------------------------------------------------------------------
module traffic_phase_arbiter #(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 10,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
`ifdef EMERGENCY_PREEMPT_EN
    input  logic       preempt,
    input  logic [1:0] preempt_dir,
`endif
    output logic [2:0] n_light,
    output logic [2:0] s_light,
    output logic [2:0] e_light,
    output logic [2:0] w_light,
    output logic [1:0] phase,
    output logic       busy,
    output logic [7:0] count,
    output logic [3:0] pend
);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;

    // Contested green ends at GREEN_MIN; clamping against GREEN_MAX only
    // matters for a misconfigured GREEN_MAX < GREEN_MIN.
    localparam int         GREEN_LEN = (GREEN_MIN < GREEN_MAX) ? GREEN_MIN : GREEN_MAX;
    localparam logic [7:0] G_LAST    = 8'(GREEN_LEN - 1);
    localparam logic [7:0] Y_LAST    = 8'(YELLOW_T - 1);
    localparam logic [7:0] A_LAST    = 8'(ALLRED_T - 1);

    state_t           state, next_state;
    logic [1:0]       ptr;          // last granted direction; rotation starts after it
    logic [1:0]       next_phase;
    logic             grant;
    logic [3:0]       green_mask;
    logic [3:0]       pend_nxt;
    logic [3:0][2:0]  lights, lights_nxt;
    logic [7:0]       count_nxt;

    // First set bit of dem scanning from+1, from+2, ... with 'from' itself last.
    // Iterating from the lowest priority upward lets the highest priority win.
    function automatic logic [1:0] pick(input logic [3:0] dem, input logic [1:0] from);
        logic [1:0] w;
        logic [1:0] idx;
        w = from;
        for (int k = 4; k >= 1; k--) begin
            idx = from + 2'(k);
            if (dem[idx]) w = idx;
        end
        return w;
    endfunction

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        next_state = state;
        next_phase = phase;
        grant      = 1'b0;
        green_mask = (state == GREEN) ? (4'b0001 << phase) : 4'b0000;

        unique case (state)
            IDLE: begin
                if (|(pend | req)) begin
                    next_state = GREEN;
                    next_phase = pick(pend | req, ptr);
                    grant      = 1'b1;
                end
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt) begin
                    next_state = GREEN;
                    next_phase = preempt_dir;
                    grant      = 1'b1;
                end
`endif
            end
            GREEN: begin
`ifdef EMERGENCY_PREEMPT_EN
                if (preempt) begin
                    if (preempt_dir != phase) next_state = YELLOW;
                end else if (count >= G_LAST && |(pend & ~green_mask)) begin
                    next_state = YELLOW;
                end
`else
                if (count >= G_LAST && |(pend & ~green_mask)) next_state = YELLOW;
`endif
            end
            YELLOW: begin
                if (count == Y_LAST) next_state = ALLRED;
            end
            ALLRED: begin
                if (count == A_LAST) begin
                    next_state = IDLE;
                    if (|pend) begin
                        next_state = GREEN;
                        next_phase = pick(pend, ptr);
                        grant      = 1'b1;
                    end
`ifdef EMERGENCY_PREEMPT_EN
                    if (preempt) begin
                        next_state = GREEN;
                        next_phase = preempt_dir;
                        grant      = 1'b1;
                    end
`endif
                end
            end
            default: next_state = IDLE;
        endcase

        // Requests from the green approach are ignored; the grant clear wins
        // over a same-edge set.
        pend_nxt = pend | (req & ~green_mask);
        if (grant) pend_nxt = pend_nxt & ~(4'b0001 << next_phase);

        count_nxt = (next_state != state) ? 8'd0 :
                    (count == 8'hFF)      ? count : count + 8'd1;

        // Lamps are decoded from the next state so they register in step with it.
        lights_nxt = {4{LAMP_RED}};
        if (next_state == GREEN)  lights_nxt[next_phase] = LAMP_GREEN;
        if (next_state == YELLOW) lights_nxt[next_phase] = LAMP_YELLOW;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            phase  <= 2'd0;
            ptr    <= 2'd3;
            pend   <= 4'd0;
            count  <= 8'd0;
            busy   <= 1'b0;
            lights <= {4{LAMP_RED}};
        end else begin
            state  <= next_state;
            phase  <= next_phase;
            if (grant) ptr <= next_phase;
            pend   <= pend_nxt;
            count  <= count_nxt;
            busy   <= (next_state != IDLE);
            lights <= lights_nxt;
        end
    end

    assign n_light = lights[0];
    assign s_light = lights[1];
    assign e_light = lights[2];
    assign w_light = lights[3];

endmodule
